cook_controller: RTL and testbench
==================================

// Module: cook_controller
// PURPOSE
//  Sequencing FSM for the microwave oven datapath. It takes one-hot keypad digits into
//  an M:SS BCD time register, and handles the start, stop and clear buttons. It enforces
//  the door interlock, counts the time down at one decrement per TICK_DIV clocks, drives
//  mag_on and flags completion. Its BCD outputs feed the 7-segment decoders.
// PARAMETERS
//  TICK_DIV  100  clock cycles per 1-second countdown tick (>=2)
// PORTS
//  clock        in   1   system clock, rising edge
//  resetn       in   1   async active-low reset
//  keypad       in   10  one-hot digit keys, bit k = digit k
//  startn       in   1   start button, active low
//  stopn        in   1   stop/pause button, active low
//  clearn       in   1   clear button, active low (level)
//  door_closed  in   1   1 = door shut
//  sec_ones     out  4   BCD seconds units
//  sec_tens     out  4   BCD seconds tens
//  mins         out  4   BCD minutes
//  mag_on       out  1   magnetron enable
//  done         out  1   cook cycle finished
//  state_o      out  3   FSM state code, for debug
// BEHAVIOUR
//  - Reset (async): state=IDLE, digits=0, prescaler=0, mag_on=0, done=0, startn_q=1, key_q=0.
//  - States (codes): IDLE=0 (time 0:00), SET=1 (time entered), COOK=2, PAUSE=3, DONE=4.
//  - Key event: keypad!=0 this cycle and key_q==0 (key_q = registered keypad!=0).
//    - If several bits are set, the lowest set bit wins.
//    - Holding a key gives one event.
//  - Start event: startn==0 with startn_q==1 (falling edge); stopn and clearn are levels.
//  - Priority per cycle: clearn > door open > stopn > start > key > tick.
//  - clearn low, any state: -> IDLE, digits=0, prescaler=0.
//  - Key event in IDLE/SET:
//    - Shift left: mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit.
//    - -> SET if the result is nonzero, otherwise stay in IDLE.
//    - Keys are ignored in COOK/PAUSE/DONE.
//  - Start in SET or PAUSE with door_closed=1 -> COOK.
//    - Start is ignored in IDLE, DONE and COOK, and whenever the door is open.
//  - COOK, door_closed=0 -> PAUSE, on the same edge the door is sampled open.
//  - COOK, stopn=0 -> PAUSE. stopn in PAUSE/SET/IDLE/DONE is ignored.
//  - Prescaler:
//    - Counts 0..TICK_DIV-1 only in COOK and is held at 0 elsewhere. Leaving COOK drops
//      any partial second.
//    - First decrement occurs TICK_DIV cycles after COOK is entered.
//  - Decrement (on tick):
//    - If sec_ones>0, sec_ones-1.
//    - Otherwise sec_ones=9 and: if sec_tens>0, sec_tens-1; otherwise sec_tens=5 and
//      mins-1.
//    - Entered tens above 5 are kept and counted through (1:90 -> 1:89 ... 1:00 -> 0:59).
//  - Reaching 0:00 on a tick -> DONE on the same edge.
//  - DONE: digits stay 0:00. Leave to IDLE on clearn=0 or door_closed=0.
//  - Outputs are decoded from registered state:
//    - mag_on = (state==COOK), so it is 1 the cycle after the start edge is sampled.
//    - mag_on is 0 the cycle after a door-open or stop is sampled.
//    - done = (state==DONE).
//  - Invariant: mag_on=1 implies door_closed was 1 at the previous edge.
//  - Async reset mid-cook: mag_on drops immediately (combinational from the state
//    register).
// TESTING  (TICK_DIV=4)
//  1. Keys 1,1,0 (separate presses) -> digits 1:10, state SET. Start -> mag_on=1 next
//     cycle. After 4 cycles -> 1:09. After 40 cycles total -> 1:00, then 0:59.
//  2. Time 0:02, start -> after 8 cycles 0:00 with done=1 and mag_on=0. Door open ->
//     IDLE, done=0.
//  3. Cooking 0:30: drop door_closed -> mag_on=0, PAUSE, time frozen. Start with the door
//     open -> stays PAUSE. Close the door, then start -> COOK resumes from the frozen
//     value.
//  4. Hold key 5 for 20 cycles -> exactly one shift, giving 0:05. Keypad=0x00A -> digit 1
//     accepted. Key pressed during COOK -> digits unchanged.
//  5. Cooking 1:00: assert clearn and stopn together -> IDLE, 0:00, mag_on=0. Start in
//     IDLE -> no effect.
//  6. Assert resetn mid-COOK -> mag_on=0 before the next edge. All outputs return to
//     reset values.

Source files
------------

// File: rtl/cook_controller.sv
// Microwave oven cook sequencer.
// Collects keypad digits into an M:SS BCD time, runs the start/stop/clear
// buttons and the door interlock, counts the time down once per TICK_DIV
// clocks while cooking, and drives the magnetron enable and done flag.
module cook_controller #(
    parameter int TICK_DIV = 100
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] mins,
    output logic       mag_on,
    output logic       done,
    output logic [2:0] state_o
);

    localparam int             PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t          state, next_state;
    logic [3:0]      ones_q, tens_q, mins_q;
    logic [3:0]      ones_d, tens_d, mins_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            key_q;
    logic            startn_q;

    logic            key_ev;
    logic            start_ev;
    logic [3:0]      key_digit;
    logic            tick;
    logic [3:0]      dec_ones, dec_tens, dec_mins;
    logic            dec_zero;
    logic            shift_zero;

    // Button edge detection: a held key or held start counts once.
    assign key_ev   = (|keypad) && !key_q;
    assign start_ev = !startn && startn_q;

    // One countdown tick on the last prescaler count while cooking.
    assign tick = (state == ST_COOK) && (presc_q == PRESC_LAST);

    // Lowest set keypad bit selects the digit when several keys are down.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        key_digit = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (keypad[k]) key_digit = 4'(k);
        end
    end

    // Result of a left shift with the new digit; zero keeps the FSM in IDLE.
    assign shift_zero = (tens_q == 4'd0) && (ones_q == 4'd0) && (key_digit == 4'd0);

    // BCD decrement of M:SS; entered tens above 5 simply count down through.
    always_comb begin
        dec_ones = ones_q;
        dec_tens = tens_q;
        dec_mins = mins_q;
        if (ones_q != 4'd0) begin
            dec_ones = ones_q - 4'd1;
        end else begin
            dec_ones = 4'd9;
            if (tens_q != 4'd0) begin
                dec_tens = tens_q - 4'd1;
            end else begin
                dec_tens = 4'd5;
                dec_mins = mins_q - 4'd1;
            end
        end
    end

    // Decrementing 0:01 is the only way to land on 0:00.
    assign dec_zero = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);

    // Next state, next time digits and next prescaler, by event priority:
    // clear > door open > stop > start > key > tick.
    always_comb begin
        next_state = state;
        ones_d     = ones_q;
        tens_d     = tens_q;
        mins_d     = mins_q;
        presc_d    = '0;

        if (!clearn) begin
            next_state = ST_IDLE;
            ones_d     = 4'd0;
            tens_d     = 4'd0;
            mins_d     = 4'd0;
        end else begin
            case (state)
                ST_IDLE, ST_SET: begin
                    if (start_ev && door_closed && (state == ST_SET)) begin
                        next_state = ST_COOK;
                    end else if (key_ev) begin
                        mins_d     = tens_q;
                        tens_d     = ones_q;
                        ones_d     = key_digit;
                        next_state = shift_zero ? ST_IDLE : ST_SET;
                    end
                end

                ST_COOK: begin
                    if (!door_closed || !stopn) begin
                        next_state = ST_PAUSE;
                    end else if (tick) begin
                        ones_d = dec_ones;
                        tens_d = dec_tens;
                        mins_d = dec_mins;
                        if (dec_zero) next_state = ST_DONE;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end

                ST_PAUSE: begin
                    if (start_ev && door_closed) next_state = ST_COOK;
                end

                ST_DONE: begin
                    if (!door_closed) next_state = ST_IDLE;
                end

                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!resetn) state <= ST_IDLE;
        else         state <= next_state;
    end

    // Time digits, prescaler and button history registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ones_q   <= 4'd0;
            tens_q   <= 4'd0;
            mins_q   <= 4'd0;
            presc_q  <= '0;
            key_q    <= 1'b0;
            startn_q <= 1'b1;
        end else begin
            ones_q   <= ones_d;
            tens_q   <= tens_d;
            mins_q   <= mins_d;
            presc_q  <= presc_d;
            key_q    <= |keypad;
            startn_q <= startn;
        end
    end

    // Outputs decoded straight from the state register, so an async reset
    // removes magnetron power without waiting for a clock.
    assign mag_on   = (state == ST_COOK);
    assign done     = (state == ST_DONE);
    assign state_o  = state;
    assign sec_ones = ones_q;
    assign sec_tens = tens_q;
    assign mins     = mins_q;

    // The magnetron may only be on if the door was shut at the previous edge.
    door_interlock_a: assert property (
        @(posedge clock) disable iff (!resetn) mag_on |-> $past(door_closed)
    );

endmodule

// File: tb/tb_cook_controller.sv
// Scoreboard bench for cook_controller with a 4-clock countdown tick.
module tb_cook_controller;

    localparam int TICK_DIV = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SET   = 3'd1;
    localparam logic [2:0] S_COOK  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic       clock = 1'b0;
    logic       resetn;
    logic [9:0] keypad;
    logic       startn, stopn, clearn, door_closed;
    logic [3:0] sec_ones, sec_tens, mins;
    logic       mag_on, done;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [16:0] val;
    } exp_t;

    exp_t sb[$];

    cook_controller #(.TICK_DIV(TICK_DIV)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .keypad      (keypad),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .mins        (mins),
        .mag_on      (mag_on),
        .done        (done),
        .state_o     (state_o)
    );

    always #5 clock = ~clock;

    // Packed view: {state, mag_on, done, mins, tens, ones}.
    function automatic logic [16:0] pack(input logic [2:0] st, input logic [3:0] m,
                                         input logic [3:0] t, input logic [3:0] o,
                                         input logic mg, input logic dn);
        return {st, mg, dn, m, t, o};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] st, input logic [3:0] m,
                            input logic [3:0] t, input logic [3:0] o,
                            input logic mg, input logic dn);
        exp_t e;
        e.tag = tag;
        e.val = pack(st, m, t, o, mg, dn);
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check(e.tag, 32'(pack(state_o, mins, sec_tens, sec_ones, mag_on, done)), 32'(e.val));
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press_key(input logic [9:0] k);
        keypad = k;
        tick(1);
        keypad = '0;
        tick(1);
    endtask

    // Start held for exactly one edge; returns just after that edge.
    task automatic press_start();
        startn = 1'b0;
        tick(1);
        startn = 1'b1;
    endtask

    task automatic do_clear();
        clearn = 1'b0;
        tick(1);
        clearn = 1'b1;
    endtask

    initial begin
        resetn      = 1'b0;
        keypad      = '0;
        startn      = 1'b1;
        stopn       = 1'b1;
        clearn      = 1'b1;
        door_closed = 1'b1;

        // Reset state
        push_exp("reset", S_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        tick(2);
        pop_cmp();
        resetn = 1'b1;
        tick(1);

        // 1: keys 1,1,0 then cook through the minute boundary
        push_exp("t1_entry_1_10", S_SET, 4'd1, 4'd1, 4'd0, 1'b0, 1'b0);
        press_key(10'h002);
        press_key(10'h002);
        press_key(10'h001);
        pop_cmp();
        push_exp("t1_start", S_COOK, 4'd1, 4'd1, 4'd0, 1'b1, 1'b0);
        press_start();
        pop_cmp();
        push_exp("t1_no_tick_yet", S_COOK, 4'd1, 4'd1, 4'd0, 1'b1, 1'b0);
        tick(3);
        pop_cmp();
        push_exp("t1_first_tick", S_COOK, 4'd1, 4'd0, 4'd9, 1'b1, 1'b0);
        tick(1);
        pop_cmp();
        push_exp("t1_1_00", S_COOK, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0);
        tick(36);
        pop_cmp();
        push_exp("t1_0_59", S_COOK, 4'd0, 4'd5, 4'd9, 1'b1, 1'b0);
        tick(4);
        pop_cmp();
        push_exp("t1_clear", S_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        do_clear();
        pop_cmp();

        // 2: 0:02 runs to DONE, door open returns to IDLE
        push_exp("t2_entry", S_SET, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0);
        press_key(10'h004);
        pop_cmp();
        press_start();
        push_exp("t2_0_01", S_COOK, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
        tick(7);
        pop_cmp();
        push_exp("t2_done", S_DONE, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        tick(1);
        pop_cmp();
        push_exp("t2_door_idle", S_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        door_closed = 1'b0;
        tick(1);
        pop_cmp();
        door_closed = 1'b1;
        tick(1);

        // 3: door pause, start ignored while open, resume, stop
        press_key(10'h008);
        press_key(10'h001);
        press_start();
        push_exp("t3_0_29", S_COOK, 4'd0, 4'd2, 4'd9, 1'b1, 1'b0);
        tick(4);
        pop_cmp();
        tick(2);
        push_exp("t3_door_pause", S_PAUSE, 4'd0, 4'd2, 4'd9, 1'b0, 1'b0);
        door_closed = 1'b0;
        tick(1);
        pop_cmp();
        push_exp("t3_start_door_open", S_PAUSE, 4'd0, 4'd2, 4'd9, 1'b0, 1'b0);
        press_start();
        tick(4);
        pop_cmp();
        door_closed = 1'b1;
        tick(2);
        push_exp("t3_resume", S_COOK, 4'd0, 4'd2, 4'd9, 1'b1, 1'b0);
        press_start();
        pop_cmp();
        push_exp("t3_full_second", S_COOK, 4'd0, 4'd2, 4'd8, 1'b1, 1'b0);
        tick(4);
        pop_cmp();
        push_exp("t3_stop", S_PAUSE, 4'd0, 4'd2, 4'd8, 1'b0, 1'b0);
        stopn = 1'b0;
        tick(1);
        stopn = 1'b1;
        pop_cmp();
        do_clear();

        // 4: zero key in IDLE, held key, multi-bit keypad, key during cook
        push_exp("t4_zero_key", S_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        press_key(10'h001);
        pop_cmp();
        push_exp("t4_held_key", S_SET, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0);
        keypad = 10'h020;
        tick(20);
        keypad = '0;
        tick(1);
        pop_cmp();
        push_exp("t4_lowest_bit", S_SET, 4'd0, 4'd5, 4'd1, 1'b0, 1'b0);
        press_key(10'h00A);
        pop_cmp();
        press_start();
        push_exp("t4_key_in_cook", S_COOK, 4'd0, 4'd5, 4'd1, 1'b1, 1'b0);
        press_key(10'h080);
        pop_cmp();
        do_clear();

        // 5: clear and stop together while cooking, start in IDLE ignored
        press_key(10'h002);
        press_key(10'h001);
        press_key(10'h001);
        press_start();
        tick(1);
        push_exp("t5_clear_stop", S_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        clearn = 1'b0;
        stopn  = 1'b0;
        tick(1);
        clearn = 1'b1;
        stopn  = 1'b1;
        pop_cmp();
        push_exp("t5_start_idle", S_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        press_start();
        tick(2);
        pop_cmp();

        // 6: async reset mid-cook
        press_key(10'h200);
        push_exp("t6_cooking", S_COOK, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0);
        press_start();
        tick(2);
        pop_cmp();
        #2;
        resetn = 1'b0;
        #1;
        push_exp("t6_async_drop", S_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        pop_cmp();
        push_exp("t6_held_reset", S_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        tick(2);
        pop_cmp();
        resetn = 1'b1;
        push_exp("t6_after_release", S_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        tick(2);
        pop_cmp();

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
